// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes/InvSubBytes engine: LANES bytes of one 128-bit state per clock,
// start/done handshake, result register published to data_out only when the whole state is done.
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         inv,
    input  logic [127:0] data_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] data_out
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [0:15][7:0] src_q, src_d;
    logic [0:15][7:0] res_q, res_d;
    logic [127:0]     out_q, out_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       bi;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        res_d   = res_q;
        out_d   = out_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bi      = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    src_d   = data_in;
                    mode_d  = inv;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Byte slice cnt*LANES .. cnt*LANES+LANES-1 goes through the lanes this cycle.
                for (int j = 0; j < LANES; j++) begin
                    bi        = 4'(int'(cnt_q) * LANES + j);
                    res_d[bi] = mode_q ? INV_SBOX[src_q[bi]] : SBOX[src_q[bi]];
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    out_d   = res_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
            out_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            res_q   <= res_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = out_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: five instances (LANES 1..16) share one stimulus stream and are
// compared every cycle against an S-box built from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_engine;

    localparam int NI = 5;
    localparam logic [127:0] V1     = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] V1_SUB = 128'h63cab7040953d051cd60e0e7ba70e18c;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         inv;
    logic [127:0] data_in;
    logic         busy_w [NI];
    logic         done_w [NI];
    logic [127:0] out_w  [NI];

    int n_vec = 0;
    int n_err = 0;
    int tcnt  = 0;

    logic [7:0]   fwd  [256];
    logic [7:0]   invt [256];
    int           acc_t   [NI];
    bit           act     [NI];
    logic [127:0] pend    [NI];
    logic [127:0] cur_out [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sub_bytes_engine #(.LANES(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .inv      (inv),
            .data_in  (data_in),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .data_out (out_w[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    task automatic build_tables();
        logic [7:0] y;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            y = 8'h00;
            if (x != 0)
                for (int c = 1; c < 256; c++)
                    if (gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
            fwd[8'(x)] = s;
            invt[s]    = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic iv);
        logic [0:15][7:0] s;
        logic [0:15][7:0] r;
        s = d;
        for (int b = 0; b < 16; b++)
            r[4'(b)] = iv ? invt[s[4'(b)]] : fwd[s[4'(b)]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs, then the timing model and all instances are compared.
    task automatic step(input logic st, input logic [127:0] d, input logic iv);
        int   n;
        logic exp_done;
        logic exp_busy;
        start   = st;
        data_in = d;
        inv     = iv;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            n = 16 >> i;
            if (rst) begin
                act[i]     = 1'b0;
                cur_out[i] = '0;
            end else if (st && (!act[i] || tcnt >= acc_t[i] + n + 1)) begin
                act[i]   = 1'b1;
                acc_t[i] = tcnt;
                pend[i]  = ref_sub(d, iv);
            end
            exp_done = act[i] && (tcnt == acc_t[i] + n);
            exp_busy = act[i] && (tcnt >= acc_t[i]) && (tcnt < acc_t[i] + n);
            if (exp_done) cur_out[i] = pend[i];
            chk($sformatf("busy L%0d t%0d", n, tcnt), {127'b0, busy_w[i]}, {127'b0, exp_busy});
            chk($sformatf("done L%0d t%0d", n, tcnt), {127'b0, done_w[i]}, {127'b0, exp_done});
            chk($sformatf("data_out L%0d t%0d", n, tcnt), out_w[i], cur_out[i]);
        end
        tcnt++;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step(1'b0, rand128(), 1'($urandom_range(0, 1)));
    endtask

    task automatic chk_all(input string tag, input logic [127:0] exp, input int upto);
        for (int i = 0; i < upto; i++)
            chk($sformatf("%s L%0d", tag, 16 >> i), out_w[i], exp);
    endtask

    initial begin
        int gap;
        build_tables();
        for (int i = 0; i < NI; i++) begin
            act[i]     = 1'b0;
            acc_t[i]   = 0;
            pend[i]    = '0;
            cur_out[i] = '0;
        end
        rst     = 1'b1;
        start   = 1'b0;
        inv     = 1'b0;
        data_in = '0;

        // reset state, start ignored while in reset
        step(1'b1, V1, 1'b0);
        step(1'b1, V1, 1'b1);
        rst = 1'b0;

        // known-answer vectors across all lane counts
        step(1'b1, V1, 1'b0);
        idle(20);
        chk_all("kat fwd", V1_SUB, NI);
        step(1'b1, V1_SUB, 1'b1);
        idle(20);
        chk_all("kat inv", V1, NI);
        step(1'b1, '0, 1'b1);
        idle(20);
        chk_all("inv zero", {16{8'h52}}, NI);
        step(1'b1, '0, 1'b0);
        idle(20);
        chk_all("fwd zero", {16{8'h63}}, NI);

        // start pulsed mid-run with other data; LANES=16 is already back in DONE and takes it
        step(1'b1, V1, 1'b0);
        step(1'b0, V1, 1'b0);
        step(1'b1, ~V1, 1'b1);
        idle(20);
        chk_all("mid start ignored", V1_SUB, NI - 1);

        // start held high: back-to-back operations, one per N+1 clocks
        repeat (20) step(1'b1, V1, 1'b0);
        idle(40);

        // reset in the second RUN cycle
        step(1'b1, V1 ^ {16{8'h5a}}, 1'b0);
        step(1'b0, V1, 1'b0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            act[i]     = 1'b0;
            cur_out[i] = '0;
            chk($sformatf("async rst busy L%0d", 16 >> i), {127'b0, busy_w[i]}, 128'd0);
            chk($sformatf("async rst done L%0d", 16 >> i), {127'b0, done_w[i]}, 128'd0);
            chk($sformatf("async rst data_out L%0d", 16 >> i), out_w[i], 128'd0);
        end
        step(1'b1, rand128(), 1'b0);
        rst = 1'b0;
        idle(20);
        step(1'b1, V1, 1'b0);
        idle(20);
        chk_all("after rst", V1_SUB, NI);

        // random states, modes and start gaps
        for (int k = 0; k < 1000; k++) begin
            step(1'b1, rand128(), 1'($urandom_range(0, 1)));
            gap = int'($urandom_range(0, 20));
            repeat (gap) step(($urandom_range(0, 9) == 0), rand128(), 1'($urandom_range(0, 1)));
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
